// File: rtl/bit_align_mc_if.sv
// Bundles the lane-side signals of bit_align_mc: the start request, the lane data words,
// the shared tap bus with per-lane load strobes, the effective-tap feedback and the status flags.
// Ports (slave = aligner side):
//   REQ_I            start request; a rising edge starts alignment
//   DATA_I / DATA_O  lane words in, combinational pass-through out (lane n at [n*W +: W])
//   LD_O             one-cycle per-lane tap load strobe
//   CNTVALUE_SET_O   proposed tap shared by all lanes
//   CNTVALUE_TRUE_I  effective tap per lane (lane n at [n*9 +: 9])
//   BUSY_O, BITALIGN_DONE_O, LANE_OK_O  status
interface bit_align_mc_if #(
  parameter int unsigned C_LANES      = 4,
  parameter int unsigned C_DATA_WIDTH = 4
) ();
  logic                              REQ_I;
  logic [C_LANES*C_DATA_WIDTH-1:0]   DATA_I;
  logic [C_LANES-1:0]                LD_O;
  logic [8:0]                        CNTVALUE_SET_O;
  logic [C_LANES*9-1:0]              CNTVALUE_TRUE_I;
  logic [C_LANES*C_DATA_WIDTH-1:0]   DATA_O;
  logic                              BUSY_O;
  logic                              BITALIGN_DONE_O;
  logic [C_LANES-1:0]                LANE_OK_O;

  modport master (
    output REQ_I, DATA_I, CNTVALUE_TRUE_I,
    input  LD_O, CNTVALUE_SET_O, DATA_O, BUSY_O, BITALIGN_DONE_O, LANE_OK_O
  );

  modport slave (
    input  REQ_I, DATA_I, CNTVALUE_TRUE_I,
    output LD_O, CNTVALUE_SET_O, DATA_O, BUSY_O, BITALIGN_DONE_O, LANE_OK_O
  );
endinterface

// File: rtl/bit_align_mc.sv
// Multi-lane IDELAY bit aligner. Lanes are handled one at a time: the tap is swept over the
// full range, each tap is judged stable if C_SAMPLES consecutive words match, and the centre
// of the longest stable window is loaded as the final tap. Per-lane pass flags are reported.
// Ports:
//   CLK_I  IDELAY control clock (only clock)
//   RST_I  synchronous active-high reset
//   bus    bit_align_mc_if slave modport (request, lane data, tap bus, status)
module bit_align_mc #(
  parameter string       C_DEVICE     = "KUP",
  parameter int unsigned C_DATA_WIDTH = 4,
  parameter int unsigned C_LANES      = 4,
  parameter int unsigned C_SETTLE     = 10,
  parameter int unsigned C_SAMPLES    = 16,
  parameter int unsigned C_MIN_WIN    = 4,
  parameter int unsigned C_TIMEOUT    = 255
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  bit_align_mc_if.slave bus
);

  localparam bit               SmallDev   = (C_DEVICE == "K7") || (C_DEVICE == "A7");
  localparam logic [8:0]       TapTop     = SmallDev ? 9'd31 : 9'd511;
  localparam logic [8:0]       TapMid     = SmallDev ? 9'd16 : 9'd256;
  localparam logic [8:0]       TapLow     = 9'd0;
  localparam int unsigned      LaneW      = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  localparam logic [LaneW-1:0] LaneLast   = LaneW'(C_LANES - 1);
  localparam logic [15:0]      SettleInit = 16'(C_SETTLE);
  localparam logic [15:0]      TimeoutMax = 16'(C_TIMEOUT);
  localparam logic [7:0]       SampleLast = 8'(C_SAMPLES - 1);
  localparam logic [9:0]       MinWin     = 10'(C_MIN_WIN);

  typedef enum logic [3:0] {
    StIdle, StScanLd, StScanWait, StSample, StEval, StFinalLd, StFinalWait, StNext, StDone
  } state_e;

  state_e                    state_q, state_d;
  logic                      req_q, req_d;
  logic                      edge_q, edge_d;
  logic [LaneW-1:0]          lane_q, lane_d;
  logic [8:0]                tap_q, tap_d;
  logic [15:0]               settle_q, settle_d;
  logic [15:0]               to_q, to_d;
  logic [7:0]                smp_q, smp_d;
  logic [C_DATA_WIDTH-1:0]   ref_q, ref_d;
  logic                      mism_q, mism_d;
  logic                      run_open_q, run_open_d;
  logic [8:0]                run_start_q, run_start_d;
  logic [9:0]                run_len_q, run_len_d;
  logic [8:0]                best_start_q, best_start_d;
  logic [9:0]                best_len_q, best_len_d;
  logic [C_LANES-1:0]        ld_q, ld_d;
  logic [8:0]                set_q, set_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [C_LANES-1:0]        lane_ok_q, lane_ok_d;

  logic [C_DATA_WIDTH-1:0]   word_arr [C_LANES];
  logic [8:0]                true_arr [C_LANES];
  logic [C_DATA_WIDTH-1:0]   word_sel;
  logic [8:0]                true_sel;
  logic [9:0]                centre;
  logic                      r_open;
  logic [8:0]                r_start;
  logic [9:0]                r_len;

  always_comb begin
    for (int i = 0; i < int'(C_LANES); i++) begin
      word_arr[i] = bus.DATA_I[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      true_arr[i] = bus.CNTVALUE_TRUE_I[i*9 +: 9];
    end
  end

  assign word_sel = word_arr[lane_q];
  assign true_sel = true_arr[lane_q];
  // Centre of the best window; the 10-bit sum is deliberately truncated to the 9-bit tap.
  assign centre   = {1'b0, best_start_q} + ((best_len_q - 10'd1) >> 1);

  assign bus.DATA_O          = bus.DATA_I;
  assign bus.LD_O            = ld_q;
  assign bus.CNTVALUE_SET_O  = set_q;
  assign bus.BUSY_O          = busy_q;
  assign bus.BITALIGN_DONE_O = done_q;
  assign bus.LANE_OK_O       = lane_ok_q;

  always_comb begin
    state_d      = state_q;
    req_d        = bus.REQ_I;
    edge_d       = bus.REQ_I & ~req_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    settle_d     = settle_q;
    to_d         = to_q;
    smp_d        = smp_q;
    ref_d        = ref_q;
    mism_d       = mism_q;
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    ld_d         = '0;
    set_d        = set_q;
    lane_ok_d    = lane_ok_q;
    r_open       = run_open_q;
    r_start      = run_start_q;
    r_len        = run_len_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (edge_q && !busy_q) begin
          lane_d    = '0;
          tap_d     = TapLow;
          lane_ok_d = '0;
          state_d   = StScanLd;
        end
      end
      StScanLd: begin
        set_d         = tap_q;
        ld_d[lane_q]  = 1'b1;
        settle_d      = SettleInit;
        to_d          = '0;
        state_d       = StScanWait;
      end
      StScanWait, StFinalWait: begin
        if (settle_q != '0) settle_d = settle_q - 16'd1;
        if (settle_q == '0 && true_sel == tap_q) begin
          smp_d   = '0;
          state_d = (state_q == StScanWait) ? StSample : StNext;
        end else if (to_q == TimeoutMax) begin
          // A scan-time timeout abandons the lane; a final-load timeout revokes its pass flag.
          if (state_q == StFinalWait) lane_ok_d[lane_q] = 1'b0;
          state_d = StNext;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      StSample: begin
        if (smp_q == '0) begin
          ref_d  = word_sel;
          mism_d = 1'b0;
        end else if (word_sel != ref_q) begin
          mism_d = 1'b1;
        end
        if (smp_q == SampleLast) state_d = StEval;
        else                     smp_d   = smp_q + 8'd1;
      end
      StEval: begin
        if (!mism_q) begin
          if (run_open_q) begin
            r_len = run_len_q + 10'd1;
          end else begin
            r_open  = 1'b1;
            r_start = tap_q;
            r_len   = 10'd1;
          end
        end
        // Strict compare keeps the earliest of equally wide windows.
        if (mism_q || tap_q == TapTop) begin
          if (r_open && r_len > best_len_q) begin
            best_start_d = r_start;
            best_len_d   = r_len;
          end
          r_open = 1'b0;
        end
        run_open_d  = r_open;
        run_start_d = r_start;
        run_len_d   = r_len;
        if (tap_q == TapTop) begin
          state_d = StFinalLd;
        end else begin
          tap_d   = tap_q + 9'd1;
          state_d = StScanLd;
        end
      end
      StFinalLd: begin
        if (best_len_q >= MinWin) begin
          tap_d             = centre[8:0];
          set_d             = centre[8:0];
          lane_ok_d[lane_q] = 1'b1;
        end else begin
          tap_d             = TapMid;
          set_d             = TapMid;
          lane_ok_d[lane_q] = 1'b0;
        end
        ld_d[lane_q] = 1'b1;
        settle_d     = SettleInit;
        to_d         = '0;
        state_d      = StFinalWait;
      end
      StNext: begin
        run_open_d   = 1'b0;
        run_start_d  = '0;
        run_len_d    = '0;
        best_start_d = '0;
        best_len_d   = '0;
        if (lane_q == LaneLast) begin
          state_d = StDone;
        end else begin
          lane_d  = lane_q + 1'b1;
          tap_d   = TapLow;
          state_d = StScanLd;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = !(state_d == StIdle || state_d == StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      edge_q       <= 1'b0;
      lane_q       <= '0;
      tap_q        <= '0;
      settle_q     <= '0;
      to_q         <= '0;
      smp_q        <= '0;
      ref_q        <= '0;
      mism_q       <= 1'b0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      ld_q         <= '0;
      set_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lane_ok_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      edge_q       <= edge_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      settle_q     <= settle_d;
      to_q         <= to_d;
      smp_q        <= smp_d;
      ref_q        <= ref_d;
      mism_q       <= mism_d;
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      ld_q         <= ld_d;
      set_q        <= set_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lane_ok_q    <= lane_ok_d;
    end
  end

endmodule
